// File: rtl/qupls_checkpoint_allocator.sv
// qupls_checkpoint_allocator: hands out free checkpoint indices to rename.
// Free pulses from the retire side and branch-miss restores return indices
// to the pool. The next grantable index is precomputed into a flop, so the
// grant path is a register output.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   alloc_req           rename group with a branch needs a checkpoint
//   alloc_rdy           a checkpoint can be granted this cycle
//   alloc_ndx           index granted when alloc_req && alloc_rdy
//   free, free_ndx      single-checkpoint free from the retire-side freer
//   restore             branch-miss restore strobe
//   restore_mask        checkpoints reclaimed on restore
//   free_cnt            registered count of free checkpoints
//   stall               alloc_req && !alloc_rdy
//   err                 one-cycle pulse on a protocol violation
//   stat_allocs/stalls  statistics counters
//
// Optional feature macro: QUPLS_CHKPT_STATS_EN enables the saturating
// statistics counters; when undefined both stat outputs read zero.

module qupls_checkpoint_allocator #(
   parameter int  NCHK = 16,
   parameter int  RSV  = 1,
   localparam int CW   = $clog2(NCHK)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alloc_req,
   output logic            alloc_rdy,
   output logic [CW-1:0]   alloc_ndx,
   input  logic            free,
   input  logic [CW-1:0]   free_ndx,
   input  logic            restore,
   input  logic [NCHK-1:0] restore_mask,
   output logic [CW:0]     free_cnt,
   output logic            stall,
   output logic            err,
   output logic [31:0]     stat_allocs,
   output logic [31:0]     stat_stalls
);

   localparam bit POW2 = (NCHK == (1 << CW));

   logic [NCHK-1:0] avail_q, avail_d;
   logic [CW-1:0]   nxt_q, nxt_d;
   logic [CW:0]     cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            grant;
   logic            free_oob;
   logic            free_bad;

   // Restore flushes rename, so no index may be consumed that cycle.
   assign alloc_rdy = !restore && (cnt_q > (CW+1)'(RSV));
   assign alloc_ndx = nxt_q;
   assign free_cnt  = cnt_q;
   assign stall     = alloc_req && !alloc_rdy;
   assign err       = err_q;
   assign grant     = alloc_req && alloc_rdy;

   assign free_oob = POW2 ? 1'b0 : (32'(free_ndx) >= 32'(NCHK));

   // Freeing the index being granted this cycle means it was never
   // allocated; it is already set in avail, but flag it explicitly.
   assign free_bad = free_oob
                   || avail_q[free_ndx]
                   || (grant && (free_ndx == nxt_q));

   always_comb begin
      avail_d = avail_q;
      if (free && !free_bad)
         avail_d[free_ndx] = 1'b1;
      if (restore)
         avail_d = avail_d | restore_mask;
      if (grant)
         avail_d[nxt_q] = 1'b0;

      // Empty pool keeps the previous index; it is don't-care then.
      nxt_d = nxt_q;
      for (int i = NCHK-1; i >= 0; i--)
         if (avail_d[i])
            nxt_d = CW'(i);

      cnt_d = '0;
      for (int i = 0; i < NCHK; i++)
         cnt_d = cnt_d + (CW+1)'(avail_d[i]);

      err_d = free && free_bad;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         avail_q <= ~NCHK'(1);
         nxt_q   <= CW'(1);
         cnt_q   <= (CW+1)'(NCHK-1);
         err_q   <= 1'b0;
      end else begin
         avail_q <= avail_d;
         nxt_q   <= nxt_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

`ifdef QUPLS_CHKPT_STATS_EN
   logic [31:0] allocs_q;
   logic [31:0] stalls_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         allocs_q <= '0;
         stalls_q <= '0;
      end else begin
         if (grant && (allocs_q != '1))
            allocs_q <= allocs_q + 32'd1;
         if (stall && (stalls_q != '1))
            stalls_q <= stalls_q + 32'd1;
      end
   end

   assign stat_allocs = allocs_q;
   assign stat_stalls = stalls_q;
`else
   assign stat_allocs = '0;
   assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_qupls_checkpoint_allocator.sv
// tb_qupls_checkpoint_allocator: directed and randomized checks of the
// checkpoint allocator against a pool model kept as a plain bit array.

module tb_qupls_checkpoint_allocator;

   localparam int NCHK = 16;
   localparam int RSV  = 1;
   localparam int CW   = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            alloc_req = 1'b0;
   logic            alloc_rdy;
   logic [CW-1:0]   alloc_ndx;
   logic            free = 1'b0;
   logic [CW-1:0]   free_ndx = '0;
   logic            restore = 1'b0;
   logic [NCHK-1:0] restore_mask = '0;
   logic [CW:0]     free_cnt;
   logic            stall;
   logic            err;
   logic [31:0]     stat_allocs;
   logic [31:0]     stat_stalls;

   int tests = 0;
   int fails = 0;

   // Pool model: mf[i] set means checkpoint i is free.
   bit mf[NCHK];
   int m_nxt;
   int m_err;
   int m_allocs;
   int m_stalls;

   qupls_checkpoint_allocator #(.NCHK(NCHK), .RSV(RSV)) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_rdy    (alloc_rdy),
      .alloc_ndx    (alloc_ndx),
      .free         (free),
      .free_ndx     (free_ndx),
      .restore      (restore),
      .restore_mask (restore_mask),
      .free_cnt     (free_cnt),
      .stall        (stall),
      .err          (err),
      .stat_allocs  (stat_allocs),
      .stat_stalls  (stat_stalls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < NCHK; i++)
         c += int'(mf[i]);
      return c;
   endfunction

   function automatic int m_low();
      for (int i = 0; i < NCHK; i++)
         if (mf[i])
            return i;
      return m_nxt;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NCHK; i++)
         mf[i] = (i != 0);
      m_nxt    = 1;
      m_err    = 0;
      m_allocs = 0;
      m_stalls = 0;
   endtask

   task automatic chk_stats();
`ifdef QUPLS_CHKPT_STATS_EN
      chk("stat_allocs", stat_allocs, m_allocs);
      chk("stat_stalls", stat_stalls, m_stalls);
`else
      chk("stat_allocs", stat_allocs, 0);
      chk("stat_stalls", stat_stalls, 0);
`endif
   endtask

   // One clock: drive, check combinational outputs, advance the model,
   // cross the edge, check registered outputs.
   task automatic cyc(input bit req, input bit fr, input int fndx,
                      input bit rs, input logic [NCHK-1:0] rm);
      bit rdy;
      bit grant;
      bit bad;
      int g;
      alloc_req    = req;
      free         = fr;
      free_ndx     = fndx[CW-1:0];
      restore      = rs;
      restore_mask = rm;
      #1;
      rdy = !rs && (m_cnt() > RSV);
      chk("alloc_rdy", alloc_rdy, rdy);
      chk("stall", stall, req && !rdy);
      if (m_cnt() > 0)
         chk("alloc_ndx", alloc_ndx, m_nxt);
      grant = req && rdy;
      g     = m_nxt;
      bad   = fr && (fndx >= NCHK || mf[fndx] || (grant && fndx == g));
      if (fr && !bad)
         mf[fndx] = 1'b1;
      if (rs)
         for (int i = 0; i < NCHK; i++)
            if (rm[i])
               mf[i] = 1'b1;
      if (grant)
         mf[g] = 1'b0;
      if (m_cnt() > 0)
         m_nxt = m_low();
      m_err = int'(bad);
      if (grant)
         m_allocs++;
      if (req && !rdy)
         m_stalls++;
      @(posedge clk);
      #1;
      chk("free_cnt", free_cnt, m_cnt());
      chk("err", err, m_err);
      if (m_cnt() > 0)
         chk("alloc_ndx_q", alloc_ndx, m_nxt);
      chk_stats();
   endtask

   initial begin
      int fi;
      logic [NCHK-1:0] rm;

      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_free_cnt", free_cnt, 15);
      chk("rst_alloc_ndx", alloc_ndx, 1);
      chk("rst_alloc_rdy", alloc_rdy, 1);
      chk("rst_err", err, 0);
      chk_stats();
      rst = 1'b0;

      for (int i = 1; i <= 14; i++) begin
         chk("seq_ndx", alloc_ndx, i);
         cyc(1'b1, 1'b0, 0, 1'b0, '0);
      end
      chk("drain_cnt", free_cnt, 1);
      chk("drain_rdy", alloc_rdy, 0);
      repeat (5) cyc(1'b1, 1'b0, 0, 1'b0, '0);
      chk("stall_hi", stall, 1);
`ifdef QUPLS_CHKPT_STATS_EN
      chk("allocs_14", stat_allocs, 14);
      chk("stalls_5", stat_stalls, 5);
`else
      chk("allocs_off", stat_allocs, 0);
      chk("stalls_off", stat_stalls, 0);
`endif

      cyc(1'b0, 1'b1, 5, 1'b0, '0);
      chk("free5_cnt", free_cnt, 2);
      chk("free5_ndx", alloc_ndx, 5);
      chk("free5_rdy", alloc_rdy, 1);

      cyc(1'b0, 1'b1, 3, 1'b0, '0);
      chk("free3_ndx", alloc_ndx, 3);
      cyc(1'b1, 1'b1, 7, 1'b0, '0);
      chk("allocfree_cnt", free_cnt, 3);
      chk("allocfree_err", err, 0);
      chk("allocfree_ndx", alloc_ndx, 5);

      cyc(1'b0, 1'b1, 9, 1'b0, '0);
      cyc(1'b0, 1'b1, 9, 1'b0, '0);
      chk("dblfree_err", err, 1);
      chk("dblfree_cnt", free_cnt, 4);
      cyc(1'b0, 1'b0, 0, 1'b0, '0);
      chk("err_pulse", err, 0);

      cyc(1'b1, 1'b1, 5, 1'b0, '0);
      chk("freegrant_err", err, 1);
      chk("freegrant_cnt", free_cnt, 3);

      alloc_req = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_cnt", free_cnt, 15);
      chk("arst_ndx", alloc_ndx, 1);
      m_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      repeat (10) cyc(1'b1, 1'b0, 0, 1'b0, '0);
      cyc(1'b1, 1'b0, 0, 1'b1, 16'h07C0);
      chk("restore_cnt", free_cnt, 10);
      chk("restore_ndx", alloc_ndx, 6);

      cyc(1'b0, 1'b0, 0, 1'b1, 16'hFFFF);
      chk("full_cnt", free_cnt, 16);
      chk("full_ndx", alloc_ndx, 0);

      for (int n = 0; n < 400; n++) begin
         fi = $urandom_range(0, NCHK-1);
         if ($urandom_range(0, 3) != 0)
            for (int k = 0; k < NCHK; k++)
               if (!mf[(fi + k) % NCHK]) begin
                  fi = (fi + k) % NCHK;
                  break;
               end
         rm = NCHK'($urandom);
         cyc(1'($urandom_range(0, 1)),
             $urandom_range(0, 2) == 0,
             fi,
             $urandom_range(0, 19) == 0,
             rm);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
